// File: rtl/updown_counter.sv
// Up/down modulo-(MAX+1) counter with load, clear, terminal-count pulse and compare.
// SATURATE picks whether the ends of the 0..MAX sequence wrap around or hold.
module updown_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] cmp,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             match
);
  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // One extra bit of headroom keeps the preset clamp and the top-end test
  // from aliasing when MAX is the full WIDTH-bit range.
  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_W = MAX_X[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out <= '0;
      tc  <= 1'b0;
    end else if (clear) begin
      out <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      out <= ({1'b0, preset} > MAX_X) ? MAX_W : preset;
      tc  <= 1'b0;
    end else if (en && up) begin
      if ({1'b0, out} >= MAX_X) begin
        tc <= 1'b1;
        if (SATURATE == MODE_WRAP) out <= '0;
      end else begin
        out <= WIDTH'({1'b0, out} + ONE_X);
        tc  <= 1'b0;
      end
    end else if (en) begin
      if (out == '0) begin
        tc <= 1'b1;
        if (SATURATE != MODE_SAT) out <= MAX_W;
      end else begin
        out <= WIDTH'({1'b0, out} - ONE_X);
        tc  <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

  assign match = (out == cmp);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench: a wrap-mode counter (MAX=9) and a saturating one (MAX=255)
// driven with hand-computed vectors.
module tb_updown_counter;
  logic       clk = 1'b0;
  logic       reset_n;

  logic       a_clear, a_load, a_en, a_up, a_tc, a_match;
  logic [7:0] a_preset, a_cmp, a_out;
  logic       b_clear, b_load, b_en, b_up, b_tc, b_match;
  logic [7:0] b_preset, b_cmp, b_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(8), .MAX(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .clear(a_clear), .load(a_load),
    .preset(a_preset), .en(a_en), .up(a_up), .cmp(a_cmp),
    .out(a_out), .tc(a_tc), .match(a_match)
  );

  updown_counter #(.WIDTH(8), .MAX(255), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset_n(reset_n), .clear(b_clear), .load(b_load),
    .preset(b_preset), .en(b_en), .up(b_up), .cmp(b_cmp),
    .out(b_out), .tc(b_tc), .match(b_match)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one rising edge, land 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] o, input logic t);
    check({tag, ".out"}, a_out, o);
    check({tag, ".tc"},  a_tc,  t);
  endtask

  task automatic chk_b(input string tag, input logic [7:0] o, input logic t);
    check({tag, ".out"}, b_out, o);
    check({tag, ".tc"},  b_tc,  t);
  endtask

  initial begin
    reset_n  = 1'b0;
    a_clear  = 0; a_load = 0; a_en = 0; a_up = 1; a_preset = 0; a_cmp = 8'd3;
    b_clear  = 0; b_load = 0; b_en = 0; b_up = 0; b_preset = 0; b_cmp = 8'd0;
    #3;
    chk_a("rst", 8'd0, 1'b0);
    check("rst.match", a_match, 1'b0);
    chk_b("rst_b", 8'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #6;

    // saturating: down at 0 holds and pulses tc every attempt
    b_en = 1; b_up = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_b($sformatf("sat_dn%0d", i), 8'd0, 1'b1);
    end
    b_en = 0;
    step(); chk_b("sat_hold", 8'd0, 1'b0);
    b_load = 1; b_preset = 8'd254;
    step(); chk_b("sat_ld", 8'd254, 1'b0);
    b_load = 0; b_en = 1; b_up = 1;
    step(); chk_b("sat_up0", 8'd255, 1'b0);
    step(); chk_b("sat_up1", 8'd255, 1'b1);
    step(); chk_b("sat_up2", 8'd255, 1'b1);
    b_up = 0;
    step(); chk_b("sat_dn_top", 8'd254, 1'b0);
    b_en = 0;

    // wrap: ten up edges 1..9 then 0, tc only on 9->0, match only at 3
    a_en = 1; a_up = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk_a($sformatf("up%0d", i), 8'(i % 10), i == 10);
      check($sformatf("up%0d.match", i), a_match, (i % 10) == 3);
    end

    // count to 3, then hold: match stays up
    for (int i = 0; i < 3; i++) step();
    chk_a("to3", 8'd3, 1'b0);
    a_en = 0;
    step(); chk_a("hold3", 8'd3, 1'b0);
    check("hold3.match", a_match, 1'b1);

    // out-of-range preset clamps to MAX, next up wraps
    a_load = 1; a_preset = 8'd12;
    step(); chk_a("ld12", 8'd9, 1'b0);
    a_load = 0; a_en = 1;
    step(); chk_a("ld_wrap", 8'd0, 1'b1);
    step(); chk_a("ld_next", 8'd1, 1'b0);

    // down through 0 wraps to MAX; direction flip takes effect immediately
    a_up = 0;
    step(); chk_a("dn1", 8'd0, 1'b0);
    step(); chk_a("dn_wrap", 8'd9, 1'b1);
    a_up = 1;
    step(); chk_a("flip", 8'd0, 1'b1);

    // clear beats load
    a_en = 0; a_load = 1; a_preset = 8'd7;
    step(); chk_a("ld7", 8'd7, 1'b0);
    a_clear = 1; a_preset = 8'd5;
    step(); chk_a("clr_ld", 8'd0, 1'b0);
    a_clear = 0; a_load = 0;

    // async reset mid-cycle at out=6
    a_en = 1; a_up = 1;
    for (int i = 0; i < 6; i++) step();
    chk_a("to6", 8'd6, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    chk_a("async_rst", 8'd0, 1'b0);
    check("async_rst.match", a_match, 1'b0);
    #2 reset_n = 1'b1;
    step(); chk_a("post_rst", 8'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
